// File: rtl/branch_predict_unit_if.sv
// Predict/resolve/statistics bundle for branch_predict_unit.
// slave is the predictor's view of the bundle; master is the pipeline's view.
interface branch_predict_unit_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
);
    logic              pred_valid_i;
    logic              pred_stall_i;
    logic [31:0]       pred_pc_i;
    logic              pred_taken_o;
    logic              res_valid_i;
    logic [31:0]       res_pc_i;
    logic [5:0]        res_op_i;
    logic [4:0]        res_rt_i;
    logic [DATA_W-1:0] res_srca_i;
    logic [DATA_W-1:0] res_srcb_i;
    logic              res_pred_i;
    logic              res_taken_o;
    logic              mispredict_o;
    logic [CNT_W-1:0]  stat_branch_o;
    logic [CNT_W-1:0]  stat_mispred_o;

    modport slave (
        input  pred_valid_i, pred_stall_i, pred_pc_i,
        input  res_valid_i, res_pc_i, res_op_i, res_rt_i, res_srca_i, res_srcb_i, res_pred_i,
        output pred_taken_o, res_taken_o, mispredict_o, stat_branch_o, stat_mispred_o
    );

    modport master (
        output pred_valid_i, pred_stall_i, pred_pc_i,
        output res_valid_i, res_pc_i, res_op_i, res_rt_i, res_srca_i, res_srcb_i, res_pred_i,
        input  pred_taken_o, res_taken_o, mispredict_o, stat_branch_o, stat_mispred_o
    );
endinterface

// File: rtl/branch_predict_unit.sv
// MIPS conditional-branch resolver with a 2-bit saturating-counter direction predictor.
// Optional gshare indexing is enabled by defining GSHARE_EN.
module branch_predict_unit #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    branch_predict_unit_if.slave  bus
);
    localparam int DEPTH = 2 ** IDX_W;

    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [4:0] RT_BLTZ   = 5'h00;
    localparam logic [4:0] RT_BGEZ   = 5'h01;
    localparam logic [4:0] RT_BLTZAL = 5'h10;
    localparam logic [4:0] RT_BGEZAL = 5'h11;

    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic up);
        logic [1:0] res;
        if (up) begin
            res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
        end else begin
            res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
        end
        return res;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    logic [1:0]        tbl_q [DEPTH];
    logic              pred_taken_q, pred_taken_d;
    logic              res_taken_q, res_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [CNT_W-1:0]  stat_branch_q, stat_branch_d;
    logic [CNT_W-1:0]  stat_mispred_q, stat_mispred_d;
    logic [IDX_W-1:0]  pred_idx_s, res_idx_s;
    logic              is_br_s, cond_s, tbl_we_s;
    logic [1:0]        tbl_wdata_s;
    logic              a_neg_s, a_zero_s;
    logic              unused_pc_s;

    assign unused_pc_s = ^{bus.pred_pc_i[31:IDX_W+2], bus.pred_pc_i[1:0],
                           bus.res_pc_i[31:IDX_W+2], bus.res_pc_i[1:0]};

`ifdef GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    assign pred_idx_s = bus.pred_pc_i[IDX_W+1:2] ^ ghr_q;
    assign res_idx_s  = bus.res_pc_i[IDX_W+1:2] ^ ghr_q;

    // Global history shifts in each resolved branch outcome.
    always_comb begin
        ghr_d = ghr_q;
        if (tbl_we_s) begin
            ghr_d = {ghr_q[IDX_W-2:0], cond_s};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // History register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ghr_q <= {IDX_W{1'b0}};
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign pred_idx_s = bus.pred_pc_i[IDX_W+1:2];
    assign res_idx_s  = bus.res_pc_i[IDX_W+1:2];
`endif

    assign a_neg_s  = bus.res_srca_i[DATA_W-1];
    assign a_zero_s = (bus.res_srca_i == {DATA_W{1'b0}});

    // Branch decode and condition evaluation for the EX instruction.
    always_comb begin
        is_br_s = 1'b0;
        cond_s  = 1'b0;
        case (bus.res_op_i)
            OP_BEQ:  begin is_br_s = 1'b1; cond_s = (bus.res_srca_i == bus.res_srcb_i); end
            OP_BNE:  begin is_br_s = 1'b1; cond_s = (bus.res_srca_i != bus.res_srcb_i); end
            OP_BGTZ: begin is_br_s = 1'b1; cond_s = !a_neg_s && !a_zero_s; end
            OP_BLEZ: begin is_br_s = 1'b1; cond_s = a_neg_s || a_zero_s; end
            OP_REGIMM: begin
                case (bus.res_rt_i)
                    RT_BGEZ, RT_BGEZAL: begin is_br_s = 1'b1; cond_s = !a_neg_s; end
                    RT_BLTZ, RT_BLTZAL: begin is_br_s = 1'b1; cond_s = a_neg_s; end
                    default:            begin is_br_s = 1'b0; cond_s = 1'b0; end
                endcase
            end
            default: begin is_br_s = 1'b0; cond_s = 1'b0; end
        endcase
    end

    assign tbl_we_s    = bus.res_valid_i && is_br_s;
    assign tbl_wdata_s = ctr_update(tbl_q[res_idx_s], cond_s);

    // Next-state for prediction, resolve outputs and statistics.
    always_comb begin
        pred_taken_d   = pred_taken_q;
        res_taken_d    = 1'b0;
        mispredict_d   = 1'b0;
        stat_branch_d  = stat_branch_q;
        stat_mispred_d = stat_mispred_q;
        if (bus.pred_stall_i) begin
            pred_taken_d = pred_taken_q;
        end else if (bus.pred_valid_i) begin
            pred_taken_d = tbl_q[pred_idx_s][1];
        end else begin
            pred_taken_d = 1'b0;
        end
        if (bus.res_valid_i) begin
            res_taken_d  = cond_s;
            mispredict_d = is_br_s && (cond_s ^ bus.res_pred_i);
        end else begin
            res_taken_d  = 1'b0;
            mispredict_d = 1'b0;
        end
        if (tbl_we_s) begin
            stat_branch_d = sat_inc(stat_branch_q);
        end else begin
            stat_branch_d = stat_branch_q;
        end
        if (bus.res_valid_i && mispredict_d) begin
            stat_mispred_d = sat_inc(stat_mispred_q);
        end else begin
            stat_mispred_d = stat_mispred_q;
        end
    end

    // Output and statistics registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pred_taken_q   <= 1'b0;
            res_taken_q    <= 1'b0;
            mispredict_q   <= 1'b0;
            stat_branch_q  <= {CNT_W{1'b0}};
            stat_mispred_q <= {CNT_W{1'b0}};
        end else begin
            pred_taken_q   <= pred_taken_d;
            res_taken_q    <= res_taken_d;
            mispredict_q   <= mispredict_d;
            stat_branch_q  <= stat_branch_d;
            stat_mispred_q <= stat_mispred_d;
        end
    end

    // Counter table; the predict read above sees the value from before this edge's write.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= 2'b01;
            end
        end else if (tbl_we_s) begin
            tbl_q[res_idx_s] <= tbl_wdata_s;
        end
    end

    assign bus.pred_taken_o   = pred_taken_q;
    assign bus.res_taken_o    = res_taken_q;
    assign bus.mispredict_o   = mispredict_q;
    assign bus.stat_branch_o  = stat_branch_q;
    assign bus.stat_mispred_o = stat_mispred_q;
endmodule
